// File: rtl/l1_tl_request_tracker_pkg.sv
// Shared TileLink parameters for the L1 request tracker: source width and
// A/D-channel opcode encodings.
package l1_tl_request_tracker_pkg;

    localparam int unsigned WSOURCE = 4;
    localparam int unsigned NSRC    = 1 << WSOURCE;

    // A-channel opcodes
    localparam logic [2:0] TL_GET     = 3'd4;
    localparam logic [2:0] TL_PUTFULL = 3'd0;

    // D-channel opcodes
    localparam logic [2:0] TL_ACK     = 3'd0;
    localparam logic [2:0] TL_ACKDATA = 3'd1;

    function automatic logic [2:0] a_opcode_for(input logic write);
        return write ? TL_PUTFULL : TL_GET;
    endfunction

endpackage

// File: rtl/l1_tl_request_tracker_src_track_table.sv
// Per-source in-flight table: one write port (grant), one clear port
// (response) and one combinational read port, all indexed by source ID.
import l1_tl_request_tracker_pkg::*;

module src_track_table #(
    parameter int unsigned TAGW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [WSOURCE-1:0]  wr_idx,
    input  logic [TAGW-1:0]     wr_tag,
    input  logic                wr_write,
    input  logic                clr_en,
    input  logic [WSOURCE-1:0]  clr_idx,
    input  logic [WSOURCE-1:0]  rd_idx,
    output logic                rd_valid,
    output logic [TAGW-1:0]     rd_tag,
    output logic                rd_write
);

    logic [NSRC-1:0] valid_q;
    logic [NSRC-1:0] write_q;
    logic [TAGW-1:0] tag_q [NSRC];

    // Valid bits: a grant wins over a clear of the same ID, so an ID freed and
    // re-granted in one cycle ends up valid; different IDs update independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (wr_en && wr_idx == WSOURCE'(i))
                    valid_q[i] <= 1'b1;
                else if (clr_en && clr_idx == WSOURCE'(i))
                    valid_q[i] <= 1'b0;
            end
        end
    end

    // Payload fields are only meaningful while the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]   <= wr_tag;
            write_q[wr_idx] <= wr_write;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_write = write_q[rd_idx];

endmodule

// File: rtl/l1_tl_request_tracker.sv
// L1 request tracker: obtains a TileLink source ID from the ID manager, issues
// one single-beat A message per L1 request, matches D responses by source and
// releases the ID with a one-cycle dealloc pulse.
import l1_tl_request_tracker_pkg::*;

module l1_tl_request_tracker #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 64,
    parameter int unsigned TAGW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AW-1:0]       req_addr,
    input  logic [DW-1:0]       req_data,
    input  logic [TAGW-1:0]     req_tag,
    output logic                alloc_req,
    input  logic                alloc_gnt,
    input  logic [WSOURCE-1:0]  alloc_source_id,
    output logic                dealloc_req,
    output logic [WSOURCE-1:0]  dealloc_source_id,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [2:0]          a_opcode,
    output logic [WSOURCE-1:0]  a_source,
    output logic [AW-1:0]       a_address,
    output logic [DW-1:0]       a_data,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [WSOURCE-1:0]  d_source,
    input  logic [DW-1:0]       d_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [TAGW-1:0]     rsp_tag,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_write,
    output logic                err_unexp
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ALLOC    = 2'd1;
    localparam logic [1:0] ST_WAIT_GNT = 2'd2;
    localparam logic [1:0] ST_ISSUE    = 2'd3;

    logic [1:0]          state_q;
    logic                lat_write;
    logic [AW-1:0]       lat_addr;
    logic [DW-1:0]       lat_data;
    logic [TAGW-1:0]     lat_tag;
    logic [WSOURCE-1:0]  cur_src;

    logic                tbl_wr_en;
    logic                tbl_valid;
    logic [TAGW-1:0]     tbl_tag;
    logic                tbl_write;
    logic                d_hs;
    logic                tbl_clr_en;

    // The D opcode is deliberately not cross-checked against the request type.
    logic                unused_d_opcode;
    assign unused_d_opcode = ^d_opcode;

    // Issue FSM and request latches; the source ID is captured in ALLOC because
    // the manager's output has already moved on when the grant arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_tag   <= '0;
            cur_src   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_data  <= req_data;
                        lat_tag   <= req_tag;
                        state_q   <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    cur_src <= alloc_source_id;
                    state_q <= ST_WAIT_GNT;
                end
                ST_WAIT_GNT: begin
                    state_q <= alloc_gnt ? ST_ISSUE : ST_ALLOC;
                end
                ST_ISSUE: begin
                    if (a_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign alloc_req = (state_q == ST_ALLOC);
    assign a_valid   = (state_q == ST_ISSUE);
    assign a_opcode  = a_valid ? a_opcode_for(lat_write) : 3'd0;
    assign a_source  = a_valid ? cur_src  : '0;
    assign a_address = a_valid ? lat_addr : '0;
    assign a_data    = a_valid ? lat_data : '0;

    assign tbl_wr_en  = (state_q == ST_WAIT_GNT) && alloc_gnt;
    assign d_ready    = !rsp_valid || rsp_ready;
    assign d_hs       = d_valid && d_ready;
    assign tbl_clr_en = d_hs && tbl_valid;

    src_track_table #(
        .TAGW (TAGW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tbl_wr_en),
        .wr_idx   (cur_src),
        .wr_tag   (lat_tag),
        .wr_write (lat_write),
        .clr_en   (tbl_clr_en),
        .clr_idx  (d_source),
        .rd_idx   (d_source),
        .rd_valid (tbl_valid),
        .rd_tag   (tbl_tag),
        .rd_write (tbl_write)
    );

    // Response register, dealloc pulse and unexpected-beat error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid         <= 1'b0;
            rsp_tag           <= '0;
            rsp_data          <= '0;
            rsp_write         <= 1'b0;
            dealloc_req       <= 1'b0;
            dealloc_source_id <= '0;
            err_unexp         <= 1'b0;
        end else begin
            dealloc_req       <= 1'b0;
            dealloc_source_id <= '0;
            err_unexp         <= 1'b0;
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_tag   <= '0;
                rsp_data  <= '0;
                rsp_write <= 1'b0;
            end
            if (d_hs) begin
                if (tbl_valid) begin
                    rsp_valid         <= 1'b1;
                    rsp_tag           <= tbl_tag;
                    rsp_write         <= tbl_write;
                    rsp_data          <= tbl_write ? '0 : d_data;
                    dealloc_req       <= 1'b1;
                    dealloc_source_id <= d_source;
                end else begin
                    err_unexp <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_tl_request_tracker.sv
// Directed bench for l1_tl_request_tracker: a cycle-by-cycle vector table for
// a Get and a Put round trip, then hand-written multi-cycle sequences.
import l1_tl_request_tracker_pkg::*;

module tb_l1_tl_request_tracker;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned TAGW = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid, req_ready, req_write;
    logic [AW-1:0]       req_addr;
    logic [DW-1:0]       req_data;
    logic [TAGW-1:0]     req_tag;
    logic                alloc_req, alloc_gnt;
    logic [WSOURCE-1:0]  alloc_source_id;
    logic                dealloc_req;
    logic [WSOURCE-1:0]  dealloc_source_id;
    logic                a_valid, a_ready;
    logic [2:0]          a_opcode;
    logic [WSOURCE-1:0]  a_source;
    logic [AW-1:0]       a_address;
    logic [DW-1:0]       a_data;
    logic                d_valid, d_ready;
    logic [2:0]          d_opcode;
    logic [WSOURCE-1:0]  d_source;
    logic [DW-1:0]       d_data;
    logic                rsp_valid, rsp_ready;
    logic [TAGW-1:0]     rsp_tag;
    logic [DW-1:0]       rsp_data;
    logic                rsp_write;
    logic                err_unexp;

    always #5 clk = ~clk;

    l1_tl_request_tracker #(
        .AW   (AW),
        .DW   (DW),
        .TAGW (TAGW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_tag           (req_tag),
        .alloc_req         (alloc_req),
        .alloc_gnt         (alloc_gnt),
        .alloc_source_id   (alloc_source_id),
        .dealloc_req       (dealloc_req),
        .dealloc_source_id (dealloc_source_id),
        .a_valid           (a_valid),
        .a_ready           (a_ready),
        .a_opcode          (a_opcode),
        .a_source          (a_source),
        .a_address         (a_address),
        .a_data            (a_data),
        .d_valid           (d_valid),
        .d_ready           (d_ready),
        .d_opcode          (d_opcode),
        .d_source          (d_source),
        .d_data            (d_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_tag           (rsp_tag),
        .rsp_data          (rsp_data),
        .rsp_write         (rsp_write),
        .err_unexp         (err_unexp)
    );

    typedef struct packed {
        logic                req_valid;
        logic                req_write;
        logic [AW-1:0]       req_addr;
        logic [DW-1:0]       req_data;
        logic [TAGW-1:0]     req_tag;
        logic                alloc_gnt;
        logic [WSOURCE-1:0]  alloc_id;
        logic                a_ready;
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [WSOURCE-1:0]  d_source;
        logic [DW-1:0]       d_data;
        logic                rsp_ready;
    } ins_t;

    typedef struct packed {
        logic                req_ready;
        logic                alloc_req;
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [WSOURCE-1:0]  a_source;
        logic [AW-1:0]       a_address;
        logic [DW-1:0]       a_data;
        logic                d_ready;
        logic                rsp_valid;
        logic [TAGW-1:0]     rsp_tag;
        logic [DW-1:0]       rsp_data;
        logic                rsp_write;
        logic                dealloc_req;
        logic [WSOURCE-1:0]  dealloc_id;
        logic                err_unexp;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t e;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;
    int   dealloc_cnt [NSRC];

    // Count every dealloc pulse per ID.
    initial for (int k = 0; k < int'(NSRC); k++) dealloc_cnt[k] = 0;
    always @(negedge clk) begin
        if (!rst && dealloc_req)
            dealloc_cnt[dealloc_source_id] = dealloc_cnt[dealloc_source_id] + 1;
    end

    function automatic ins_t idle_in();
        ins_t i;
        i = '0;
        i.rsp_ready = 1'b1;
        return i;
    endfunction

    function automatic outs_t quiet();
        outs_t o;
        o = '0;
        o.req_ready = 1'b1;
        o.d_ready   = 1'b1;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.req_ready   = req_ready;
        o.alloc_req   = alloc_req;
        o.a_valid     = a_valid;
        o.a_opcode    = a_opcode;
        o.a_source    = a_source;
        o.a_address   = a_address;
        o.a_data      = a_data;
        o.d_ready     = d_ready;
        o.rsp_valid   = rsp_valid;
        o.rsp_tag     = rsp_tag;
        o.rsp_data    = rsp_data;
        o.rsp_write   = rsp_write;
        o.dealloc_req = dealloc_req;
        o.dealloc_id  = dealloc_source_id;
        o.err_unexp   = err_unexp;
        return o;
    endfunction

    task automatic drive(input ins_t i);
        req_valid       = i.req_valid;
        req_write       = i.req_write;
        req_addr        = i.req_addr;
        req_data        = i.req_data;
        req_tag         = i.req_tag;
        alloc_gnt       = i.alloc_gnt;
        alloc_source_id = i.alloc_id;
        a_ready         = i.a_ready;
        d_valid         = i.d_valid;
        d_opcode        = i.d_opcode;
        d_source        = i.d_source;
        d_data          = i.d_data;
        rsp_ready       = i.rsp_ready;
    endtask

    task automatic add(input ins_t i, input outs_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vq.push_back(v);
    endtask

    task automatic chk_outs(input string name, input outs_t got, input outs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One D beat presented for a single cycle (accepted when d_ready is high).
    task automatic d_beat(input logic [WSOURCE-1:0] src, input logic [DW-1:0] data,
                          input logic [2:0] opc);
        d_valid  = 1'b1;
        d_source = src;
        d_data   = data;
        d_opcode = opc;
        cyc();
        d_valid  = 1'b0;
    endtask

    // Full request with an immediate grant of ID id; leaves the FSM in IDLE.
    task automatic issue(input logic [TAGW-1:0] tag, input logic [WSOURCE-1:0] id,
                         input logic wr);
        req_valid = 1'b1;
        req_write = wr;
        req_tag   = tag;
        req_addr  = 32'h3000 + AW'(id);
        req_data  = 64'h5000 + DW'(id);
        cyc();
        req_valid       = 1'b0;
        alloc_source_id = id;
        cyc();
        alloc_gnt       = 1'b1;
        alloc_source_id = ~id;
        cyc();
        alloc_gnt = 1'b0;
        a_ready   = 1'b1;
        @(negedge clk);
        chk("issue_a_source", {a_valid, a_source}, {1'b1, id});
        cyc();
        a_ready = 1'b0;
    endtask

    initial begin
        ins_t i;
        outs_t e;
        int snap [NSRC];
        int unsigned order [4];
        logic [5:0] pat;

        // ---------------- vector table: Get then Put round trips ------------
        i = idle_in(); i.req_valid = 1'b1; i.req_addr = 32'h1000; i.req_tag = 4'd3;
        add(i, quiet());
        i = idle_in(); i.alloc_id = 4'd0;
        e = '0; e.alloc_req = 1'b1; e.d_ready = 1'b1; add(i, e);
        i = idle_in(); i.alloc_gnt = 1'b1; i.alloc_id = 4'h9;
        e = '0; e.d_ready = 1'b1; add(i, e);
        i = idle_in(); i.a_ready = 1'b1;
        e = '0; e.d_ready = 1'b1; e.a_valid = 1'b1; e.a_opcode = TL_GET;
        e.a_source = 4'd0; e.a_address = 32'h1000; add(i, e);
        i = idle_in(); i.d_valid = 1'b1; i.d_source = 4'd0; i.d_opcode = TL_ACKDATA;
        i.d_data = 64'hDEAD; add(i, quiet());
        i = idle_in(); i.req_valid = 1'b1; i.req_write = 1'b1; i.req_addr = 32'h2000;
        i.req_data = 64'h1234_5678; i.req_tag = 4'd9;
        e = quiet(); e.rsp_valid = 1'b1; e.rsp_tag = 4'd3; e.rsp_data = 64'hDEAD;
        e.dealloc_req = 1'b1; e.dealloc_id = 4'd0; add(i, e);
        i = idle_in(); i.alloc_id = 4'd2;
        e = '0; e.alloc_req = 1'b1; e.d_ready = 1'b1; add(i, e);
        i = idle_in(); i.alloc_gnt = 1'b1; i.alloc_id = 4'hF;
        e = '0; e.d_ready = 1'b1; add(i, e);
        i = idle_in();
        e = '0; e.d_ready = 1'b1; e.a_valid = 1'b1; e.a_opcode = TL_PUTFULL;
        e.a_source = 4'd2; e.a_address = 32'h2000; e.a_data = 64'h1234_5678; add(i, e);
        i.a_ready = 1'b1; add(i, e);
        i = idle_in(); i.d_valid = 1'b1; i.d_source = 4'd2; i.d_opcode = TL_ACK;
        i.d_data = 64'hFFFF; add(i, quiet());
        i = idle_in();
        e = quiet(); e.rsp_valid = 1'b1; e.rsp_tag = 4'd9; e.rsp_write = 1'b1;
        e.dealloc_req = 1'b1; e.dealloc_id = 4'd2; add(i, e);
        i = idle_in(); i.d_valid = 1'b1; i.d_source = 4'd7; i.d_data = 64'h77;
        add(i, quiet());
        i = idle_in(); e = quiet(); e.err_unexp = 1'b1; add(i, e);
        i = idle_in(); i.d_valid = 1'b1; i.d_source = 4'd0; i.d_opcode = TL_ACKDATA;
        add(i, quiet());
        i = idle_in(); e = quiet(); e.err_unexp = 1'b1; add(i, e);
        i = idle_in(); add(i, quiet());

        // ---------------- reset ---------------------------------------------
        rst = 1'b1;
        drive(idle_in());
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_outs("reset_state", sample(), quiet());
        cyc();

        for (int n = 0; n < vq.size(); n++) begin
            drive(vq[n].i);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", n), sample(), vq[n].e);
            cyc();
        end
        drive(idle_in());

        // ---------------- four requests, out-of-order responses -------------
        for (int k = 0; k < int'(NSRC); k++) snap[k] = dealloc_cnt[k];
        for (int k = 0; k < 4; k++) issue(TAGW'(4 + k), WSOURCE'(k), 1'b0);
        order = '{2, 0, 3, 1};
        for (int n = 0; n < 4; n++) begin
            d_beat(WSOURCE'(order[n]), 64'hA0 + DW'(order[n]), TL_ACKDATA);
            @(negedge clk);
            chk("ooo_rsp", {rsp_valid, rsp_tag, rsp_data, dealloc_req, dealloc_source_id},
                {1'b1, TAGW'(4 + order[n]), 64'hA0 + DW'(order[n]), 1'b1, WSOURCE'(order[n])});
            cyc();
        end
        cyc();
        for (int k = 0; k < 4; k++)
            chk($sformatf("dealloc_once_id%0d", k), 64'(dealloc_cnt[k] - snap[k]), 64'd1);

        // ---------------- manager full: retries every 2 cycles ---------------
        req_valid = 1'b1; req_write = 1'b0; req_tag = 4'hA; req_addr = 32'h5000;
        cyc();
        req_valid = 1'b0; alloc_source_id = 4'd3; alloc_gnt = 1'b0;
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pat = {pat[4:0], alloc_req};
            cyc();
        end
        chk("retry_pattern", 64'(pat), 64'b101010);
        alloc_source_id = 4'd5;
        @(negedge clk);
        chk("retry_alloc_again", 64'(alloc_req), 64'd1);
        cyc();
        alloc_gnt = 1'b1; alloc_source_id = 4'd3;
        cyc();
        alloc_gnt = 1'b0; a_ready = 1'b1;
        @(negedge clk);
        chk("retry_a_source", {a_valid, a_source}, {1'b1, 4'd5});
        cyc();
        a_ready = 1'b0;
        d_beat(4'd5, 64'h55, TL_ACKDATA);
        @(negedge clk);
        chk("retry_rsp", {rsp_valid, rsp_tag, dealloc_source_id}, {1'b1, 4'hA, 4'd5});
        cyc();
        d_beat(4'd3, 64'h33, TL_ACKDATA);
        @(negedge clk);
        chk("retry_no_entry", {err_unexp, rsp_valid, dealloc_req}, {1'b1, 1'b0, 1'b0});
        cyc();

        // ---------------- free and re-grant of the same ID in one cycle -----
        issue(4'hB, 4'd6, 1'b0);
        req_valid = 1'b1; req_tag = 4'hC; req_addr = 32'h6000;
        cyc();
        req_valid = 1'b0; alloc_source_id = 4'd6;
        cyc();
        alloc_gnt = 1'b1;
        d_valid = 1'b1; d_source = 4'd6; d_data = 64'h66; d_opcode = TL_ACKDATA;
        cyc();
        alloc_gnt = 1'b0; d_valid = 1'b0; a_ready = 1'b1;
        @(negedge clk);
        chk("same_id_old_rsp", {rsp_valid, rsp_tag, dealloc_req, dealloc_source_id, a_source},
            {1'b1, 4'hB, 1'b1, 4'd6, 4'd6});
        cyc();
        a_ready = 1'b0;
        d_beat(4'd6, 64'h67, TL_ACKDATA);
        @(negedge clk);
        chk("same_id_new_entry", {rsp_valid, rsp_tag, rsp_data, err_unexp},
            {1'b1, 4'hC, 64'h67, 1'b0});
        cyc();

        // ---------------- response backpressure -----------------------------
        issue(4'hE, 4'd1, 1'b0);
        rsp_ready = 1'b0;
        d_beat(4'd1, 64'hBEEF, TL_ACKDATA);
        d_valid = 1'b1; d_source = 4'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d", c),
                {d_ready, rsp_valid, rsp_tag, rsp_data, err_unexp, dealloc_req},
                {1'b0, 1'b1, 4'hE, 64'hBEEF, 1'b0, (c == 0)});
            cyc();
        end
        d_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", {d_ready, rsp_valid}, {1'b1, 1'b1});
        cyc();
        @(negedge clk);
        chk("stall_drained", {rsp_valid, err_unexp}, {1'b0, 1'b0});
        cyc();

        // ---------------- reset while in ISSUE ------------------------------
        issue(4'h3, 4'd4, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_tag = 4'h2; req_addr = 32'h7000;
        cyc();
        req_valid = 1'b0; alloc_source_id = 4'd12;
        cyc();
        alloc_gnt = 1'b1;
        cyc();
        alloc_gnt = 1'b0;
        @(negedge clk);
        chk("pre_reset_issue", {a_valid, a_source}, {1'b1, 4'd12});
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk_outs("mid_reset", sample(), quiet());
        cyc();
        rst = 1'b0;
        d_beat(4'd4, 64'h44, TL_ACKDATA);
        @(negedge clk);
        chk("reset_cleared_id4", {err_unexp, rsp_valid, dealloc_req}, {1'b1, 1'b0, 1'b0});
        cyc();
        d_beat(4'd12, 64'h12, TL_ACK);
        @(negedge clk);
        chk("reset_cleared_id12", {err_unexp, rsp_valid, dealloc_req}, {1'b1, 1'b0, 1'b0});
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
